// File: rtl/maple_in_pkg.sv
// Shared definitions for the Maple bus receiver: FSM encoding, pattern
// pulse defaults and the REG_INCTRL control/status bit layout.
package maple_in_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA_A,
    ST_DATA_B,
    ST_END
  } state_e;

  localparam int unsigned START_PULSES_DEF = 4;
  localparam int unsigned END_PULSES_DEF   = 2;
  localparam int unsigned CNT_W            = 3;

  // REG_INCTRL write bits
  localparam int unsigned INCTRL_ARM = 0;
  localparam int unsigned INCTRL_CLR = 1;

  // REG_INCTRL read bits
  localparam int unsigned STAT_FRAMING = 0;
  localparam int unsigned STAT_OVERFLOW = 1;
  localparam int unsigned STAT_TIMEOUT = 2;
  localparam int unsigned STAT_BUSY = 3;
  localparam int unsigned STAT_ARMED = 4;

  function automatic logic [4:0] inctrl_status(input logic armed, input logic busy,
                                               input logic err_timeout, input logic err_overflow,
                                               input logic err_framing);
    logic [4:0] st;
    st                = '0;
    st[STAT_ARMED]    = armed;
    st[STAT_BUSY]     = busy;
    st[STAT_TIMEOUT]  = err_timeout;
    st[STAT_OVERFLOW] = err_overflow;
    st[STAT_FRAMING]  = err_framing;
    return st;
  endfunction

  function automatic logic [1:0] inctrl_decode(input logic [7:0] wdata);
    return {wdata[INCTRL_CLR], wdata[INCTRL_ARM]};
  endfunction

endpackage

// File: rtl/maple_in_sync_edge.sv
// Two-flop synchronizer plus rise/fall detection for one Maple line.
// Synced value and prev flop both preset to 1 (idle line level).
module maple_in_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  // next-state for synchronizer chain and previous-sample flop
  always_comb begin
    sync_d = {sync_q[0], din};
    prev_d = sync_q[1];
  end

  // registers, preset to idle-high on reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign s    = sync_q[1];
  assign rise = sync_q[1] & ~prev_q;
  assign fall = ~sync_q[1] & prev_q;

endmodule

// File: rtl/maple_in.sv
// Maple bus receiver: detects start pattern, deserializes alternating-phase
// bits MSB-first into bytes, detects end pattern and pushes bytes to the FIFO.
module maple_in #(
  parameter int unsigned TIMEOUT_TICKS = 255,
  parameter int unsigned START_PULSES  = maple_in_pkg::START_PULSES_DEF,
  parameter int unsigned END_PULSES    = maple_in_pkg::END_PULSES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_p1,
  input  logic       in_p5,
  input  logic       tick,
  input  logic       arm,
  input  logic       tx_active,
  input  logic       clear_err,
  input  logic       fifo_full,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       busy,
  output logic       armed,
  output logic       frame_done,
  output logic       err_framing,
  output logic       err_overflow,
  output logic       err_timeout,
  output logic [7:0] byte_count
);
  import maple_in_pkg::*;

  localparam logic [CNT_W-1:0] START_N  = CNT_W'(START_PULSES);
  localparam logic [CNT_W-1:0] END_N    = CNT_W'(END_PULSES);
  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT_TICKS - 1);

  logic s1, s1_rise, s1_fall, s5, s5_rise, s5_fall;

  maple_in_sync_edge u_sync_p1 (.clk(clk), .rst(rst), .din(in_p1), .s(s1), .rise(s1_rise), .fall(s1_fall));
  maple_in_sync_edge u_sync_p5 (.clk(clk), .rst(rst), .din(in_p5), .s(s5), .rise(s5_rise), .fall(s5_fall));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, ecnt_q, ecnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d, tmo_q, tmo_d;
  logic [7:0]       rx_data_q, rx_data_d, byte_count_q, byte_count_d;
  logic             rx_strobe_q, rx_strobe_d, frame_done_q, frame_done_d, armed_q, armed_d;
  logic             err_framing_q, err_framing_d, err_overflow_q, err_overflow_d;
  logic             err_timeout_q, err_timeout_d;
  logic             any_edge, timeout, take_bit, bit_val;
  logic [7:0]       shifted;

  // receive FSM, timeout counter and sticky error next-state
  always_comb begin
    state_d        = state_q;
    pcnt_d         = pcnt_q;
    ecnt_d         = ecnt_q;
    bitcnt_d       = bitcnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    byte_count_d   = byte_count_q;
    rx_strobe_d    = 1'b0;
    frame_done_d   = 1'b0;
    armed_d        = armed_q;
    err_framing_d  = err_framing_q;
    err_overflow_d = err_overflow_q;
    err_timeout_d  = err_timeout_q;
    take_bit       = 1'b0;
    bit_val        = 1'b0;

    any_edge = s1_rise | s1_fall | s5_rise | s5_fall;
    timeout  = (state_q != ST_IDLE) && !any_edge && tick && (tmo_q == TMO_LAST);

    if (state_q == ST_IDLE || any_edge) tmo_d = '0;
    else if (tick)                      tmo_d = tmo_q + 8'd1;
    else                                tmo_d = tmo_q;

    // clear first so an error raised this cycle still lands
    if (clear_err) begin
      err_framing_d  = 1'b0;
      err_overflow_d = 1'b0;
      err_timeout_d  = 1'b0;
    end

    if (state_q == ST_IDLE) begin
      if (arm) armed_d = 1'b1;
      if (armed_q && !tx_active && s1_fall && s5) begin
        state_d      = ST_START;
        pcnt_d       = '0;
        byte_count_d = '0;
        bitcnt_d     = '0;
        shift_d      = '0;
      end
    end else if (tx_active) begin
      state_d = ST_IDLE;
    end else if (s1_fall && s5_fall) begin
      err_framing_d = 1'b1;
      state_d       = ST_IDLE;
    end else if (timeout) begin
      err_timeout_d = 1'b1;
      armed_d       = 1'b0;
      state_d       = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_START: begin
          if (s1_rise) begin
            if (pcnt_q == START_N) begin
              state_d  = ST_DATA_A;
              bitcnt_d = '0;
              shift_d  = '0;
            end else begin
              err_framing_d = 1'b1;
              state_d       = ST_IDLE;
            end
          end else if (s5_fall && !s1 && pcnt_q != '1) begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
        ST_DATA_A: begin
          if (s1_fall) begin
            take_bit = 1'b1;
            bit_val  = s5;
            state_d  = ST_DATA_B;
          end
        end
        ST_DATA_B: begin
          if (s1_fall && !s5) begin
            if (bitcnt_q == 3'd1) begin
              state_d = ST_END;
              ecnt_d  = CNT_W'(1);
            end else begin
              err_framing_d = 1'b1;
              state_d       = ST_IDLE;
            end
          end else if (s5_fall) begin
            take_bit = 1'b1;
            bit_val  = s1;
            state_d  = ST_DATA_A;
          end
        end
        ST_END: begin
          if (s1_fall && !s5) begin
            if (ecnt_q != '1) ecnt_d = ecnt_q + 1'b1;
          end else if (s5_rise) begin
            state_d = ST_IDLE;
            if (ecnt_q == END_N) begin
              frame_done_d = 1'b1;
              armed_d      = 1'b0;
            end else begin
              err_framing_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    shifted = {shift_q[6:0], bit_val};
    if (take_bit) begin
      shift_d  = shifted;
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        rx_data_d = shifted;
        if (fifo_full) begin
          err_overflow_d = 1'b1;
        end else begin
          rx_strobe_d = 1'b1;
          if (byte_count_q != 8'hFF) byte_count_d = byte_count_q + 8'd1;
        end
      end
    end
  end

  // all receiver state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      pcnt_q         <= '0;
      ecnt_q         <= '0;
      bitcnt_q       <= '0;
      shift_q        <= '0;
      tmo_q          <= '0;
      rx_data_q      <= '0;
      byte_count_q   <= '0;
      rx_strobe_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      armed_q        <= 1'b0;
      err_framing_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      ecnt_q         <= ecnt_d;
      bitcnt_q       <= bitcnt_d;
      shift_q        <= shift_d;
      tmo_q          <= tmo_d;
      rx_data_q      <= rx_data_d;
      byte_count_q   <= byte_count_d;
      rx_strobe_q    <= rx_strobe_d;
      frame_done_q   <= frame_done_d;
      armed_q        <= armed_d;
      err_framing_q  <= err_framing_d;
      err_overflow_q <= err_overflow_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_strobe    = rx_strobe_q;
  assign busy         = (state_q != ST_IDLE);
  assign armed        = armed_q;
  assign frame_done   = frame_done_q;
  assign err_framing  = err_framing_q;
  assign err_overflow = err_overflow_q;
  assign err_timeout  = err_timeout_q;
  assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_maple_in.sv
// Scoreboard bench for the Maple receiver.
module tb_maple_in;

  localparam int GAP = 6;

  logic       clk = 1'b0;
  logic       rst, in_p1, in_p5, tick, arm, tx_active, clear_err, fifo_full;
  logic [7:0] rx_data, byte_count;
  logic       rx_strobe, busy, armed, frame_done, err_framing, err_overflow, err_timeout;

  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] exp_q[$];
  int         tdiv = 0;

  always #5 clk = ~clk;

  maple_in #(.TIMEOUT_TICKS(8)) dut (
    .clk(clk), .rst(rst), .in_p1(in_p1), .in_p5(in_p5), .tick(tick), .arm(arm),
    .tx_active(tx_active), .clear_err(clear_err), .fifo_full(fifo_full),
    .rx_data(rx_data), .rx_strobe(rx_strobe), .busy(busy), .armed(armed),
    .frame_done(frame_done), .err_framing(err_framing), .err_overflow(err_overflow),
    .err_timeout(err_timeout), .byte_count(byte_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // tick every 4 clocks
  always @(negedge clk) begin
    tdiv = (tdiv + 1) % 4;
    tick = (tdiv == 0);
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && rx_strobe) begin
      if (exp_q.size() == 0) check("unexpected_strobe", {24'h0, rx_data}, 32'hFFFF_FFFF);
      else check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
    end
    if (frame_done) done_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic drive(input logic p1, input logic p5);
    in_p1 = p1;
    in_p5 = p5;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1; @(negedge clk); arm = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1; @(negedge clk); clear_err = 1'b0; @(negedge clk);
  endtask

  task automatic send_start(input int n);
    drive(1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
    end
    drive(1'b1, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i > 0; i -= 2) begin
      drive(1'b1, b[i]);
      drive(1'b0, b[i]);
      drive(b[i-1], 1'b1);
      drive(b[i-1], 1'b0);
    end
  endtask

  task automatic send_end();
    drive(1'b1, 1'b0); drive(1'b0, 1'b0);
    drive(1'b1, 1'b0); drive(1'b0, 1'b0);
    drive(1'b1, 1'b0); drive(1'b0, 1'b0);
    drive(1'b0, 1'b1); drive(1'b1, 1'b1);
  endtask

  initial begin
    int d0;
    int waited;
    logic [7:0] frame4 [4];
    frame4[0] = 8'h00; frame4[1] = 8'hFF; frame4[2] = 8'h12; frame4[3] = 8'h80;
    rst = 1'b0; in_p1 = 1'b1; in_p5 = 1'b1; arm = 1'b0; tx_active = 1'b0;
    clear_err = 1'b0; fifo_full = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_armed", armed, 0);
    check("rst_errs", {err_framing, err_overflow, err_timeout}, 0);
    check("rst_outs", {rx_data, byte_count, rx_strobe, frame_done}, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // single byte frame
    pulse_arm();
    check("armed_set", armed, 1);
    d0 = done_cnt;
    exp_q.push_back(8'hA5);
    send_start(4); send_byte(8'hA5); send_end();
    check("f1_done", done_cnt, d0 + 1);
    check("f1_count", byte_count, 1);
    check("f1_errs", {err_framing, err_overflow, err_timeout}, 0);
    check("f1_armed", armed, 0);

    // four byte frame
    pulse_arm();
    d0 = done_cnt;
    send_start(4);
    foreach (frame4[i]) begin
      exp_q.push_back(frame4[i]);
      send_byte(frame4[i]);
    end
    send_end();
    check("f4_done", done_cnt, d0 + 1);
    check("f4_count", byte_count, 4);
    check("f4_armed", armed, 0);
    check("f4_busy", busy, 0);

    // short start pattern
    pulse_arm();
    send_start(3);
    check("short_framing", err_framing, 1);
    check("short_busy", busy, 0);
    check("short_armed", armed, 1);
    pulse_clear();
    check("short_cleared", err_framing, 0);

    // frozen lines -> timeout
    send_start(4);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    waited = 0;
    while (busy && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check("tmo_not_early", (waited + GAP) >= 31, 1);
    check("tmo_not_late", (waited + GAP) <= 36, 1);
    check("tmo_flag", err_timeout, 1);
    check("tmo_armed", armed, 0);
    drive(1'b1, 1'b1);
    pulse_clear();
    check("tmo_cleared", err_timeout, 0);

    // overflow on second byte
    pulse_arm();
    d0 = done_cnt;
    exp_q.push_back(8'h3C);
    send_start(4); send_byte(8'h3C);
    fifo_full = 1'b1;
    send_byte(8'hC3);
    fifo_full = 1'b0;
    send_end();
    check("ovf_flag", err_overflow, 1);
    check("ovf_done", done_cnt, d0 + 1);
    check("ovf_framing", err_framing, 0);
    pulse_clear();
    check("ovf_cleared", err_overflow, 0);

    // unarmed frame is ignored
    busy_seen = 1'b0;
    d0 = done_cnt;
    send_start(4); send_byte(8'h55); send_end();
    check("unarmed_busy", busy_seen, 0);
    check("unarmed_done", done_cnt, d0);

    // transmitter takes the bus mid-frame
    pulse_arm();
    send_start(4);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    tx_active = 1'b1;
    repeat (3) @(negedge clk);
    check("tx_busy", busy, 0);
    check("tx_errs", {err_framing, err_overflow, err_timeout}, 0);
    check("tx_armed", armed, 1);
    drive(1'b1, 1'b1);
    tx_active = 1'b0;
    @(negedge clk);

    // simultaneous falls in DATA
    send_start(4);
    drive(1'b0, 1'b0);
    check("sim_framing", err_framing, 1);
    check("sim_busy", busy, 0);
    drive(1'b1, 1'b1);
    pulse_clear();

    // reset mid-frame
    send_start(4);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_state", {busy, armed, rx_strobe}, 0);
    check("rstmid_count", byte_count, 0);
    rst = 1'b1;
    drive(1'b1, 1'b1);

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
